mux_arb: RTL and testbench

- Parametrised successor to the combinational 4:1 selector: NCH channels of DW bits, each with a valid/ready handshake.
- Selects one channel per cycle, either by an explicit select (fixed mode) or by round-robin arbitration, and registers the result into a one-entry output stage.
- Sits between multiple producers and a single consumer in the NPC datapath/test harness; consumer sees one registered stream tagged with source channel.

---
 rtl/mux_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 30 +++
 rtl/mux_arb.sv | 114 +++++++++++
 tb/tb_mux_arb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the mux_arb channel selector.
// Included by mux_arb and rr_pick.
package mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int unsigned CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: returns the first requester at or after ptr,
// wrapping modulo NCH. NCH must be a power of two so the wrap is plain SELW-bit overflow.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter  int unsigned NCH  = 4,
    localparam int unsigned SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            any
);

    logic [SELW-1:0] cand;

    always_comb begin
        idx  = '0;
        cand = '0;
        any  = |req;
        // Scan farthest offset first so the closest requester to ptr is written last.
        for (int k = NCH - 1; k >= 0; k--) begin
            cand = ptr + SELW'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_arb.sv
// NCH-channel valid/ready selector (fixed select or round-robin) with a one-entry output register.
// Define MUX_ARB_CNT_EN to build the 16-bit output handshake counter behind xfer_cnt.
module mux_arb
    import mux_arb_pkg::*;
#(
    parameter  int unsigned NCH  = 4,
    parameter  int unsigned DW   = 2,
    localparam int unsigned SELW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*DW-1:0] in_data,
    output logic [NCH-1:0]    in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [SELW-1:0]   out_ch,
    output logic [CNT_W-1:0]  xfer_cnt
);

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    logic            load;
    logic [SELW-1:0] gnt;
    logic            gnt_vld;
    logic [SELW-1:0] rr_idx;
    logic            rr_any;

    rr_pick #(
        .NCH (NCH)
    ) u_rr_pick (
        .req (in_valid),
        .ptr (ptr_q),
        .idx (rr_idx),
        .any (rr_any)
    );

    always_comb begin
        load        = !out_valid_q || out_ready;
        gnt         = sel;
        gnt_vld     = in_valid[sel];
        in_ready    = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;

        if (mode == MODE_RR) begin
            gnt     = rr_idx;
            gnt_vld = rr_any;
        end

        // A held entry is only replaced when the consumer takes it this cycle.
        if (load) begin
            out_valid_d = gnt_vld;
            if (gnt_vld) begin
                in_ready[gnt] = 1'b1;
                out_data_d    = in_data[gnt*DW +: DW];
                out_ch_d      = gnt;
                if (mode == MODE_RR) begin
                    ptr_d = gnt + SELW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

`ifdef MUX_ARB_CNT_EN
    cnt_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_q && out_ready) begin
            cnt_d = cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_arb.sv
// Directed, scoreboard-checked bench for mux_arb (NCH=4, DW=2).
// Expected outputs are queued when stimulus is driven and popped on each output handshake.
module tb_mux_arb;

    localparam int NCH  = 4;
    localparam int DW   = 2;
    localparam int SELW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              mode;
    logic [SELW-1:0]   sel;
    logic [NCH-1:0]    in_valid;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [SELW-1:0]   out_ch;
    logic [15:0]       xfer_cnt;

    typedef struct packed {
        logic [SELW-1:0] ch;
        logic [DW-1:0]   data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          gcount[NCH];
    logic [15:0] exp_cnt = '0;

    mux_arb #(
        .NCH (NCH),
        .DW  (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat(input logic [SELW-1:0] c);
        return in_data[c*DW +: DW];
    endfunction

    function automatic logic [15:0] cnt_exp();
`ifdef MUX_ARB_CNT_EN
        return exp_cnt;
`else
        return 16'h0;
`endif
    endfunction

    task automatic push(input logic [SELW-1:0] c);
        exp_t e;
        e.ch   = c;
        e.data = dat(c);
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("sb_ch", 32'(out_ch), 32'(e.ch));
                chk("sb_data", 32'(out_data), 32'(e.data));
                gcount[e.ch]++;
                exp_cnt++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        rst = 1'b0;

        // Fixed mode, sel=2, all channels valid.
        mode      = 1'b0;
        sel       = 2'd2;
        in_valid  = 4'b1111;
        in_data   = 8'b11_10_01_00;
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("fix_in_ready", 32'(in_ready), 32'b0100);
            push(2'd2);
            tick();
            chk("fix_out_valid", 32'(out_valid), 32'd1);
            chk("fix_out_ch", 32'(out_ch), 32'd2);
            chk("fix_out_data", 32'(out_data), 32'd2);
        end

        // Fixed mode, selected channel idle while another is valid.
        sel      = 2'd1;
        in_valid = 4'b0100;
        #1;
        chk("unsel_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("unsel_out_valid", 32'(out_valid), 32'd0);
        chk("unsel_hold_ch", 32'(out_ch), 32'd2);
        chk("unsel_hold_data", 32'(out_data), 32'd2);
        tick();
        chk("unsel_out_valid2", 32'(out_valid), 32'd0);
        chk("unsel_in_ready2", 32'(in_ready), 32'd0);

        // Round-robin fairness over 8 cycles.
        for (int c = 0; c < NCH; c++) gcount[c] = 0;
        mode     = 1'b1;
        in_valid = 4'b1111;
        in_data  = 8'b00_01_10_11;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("rr_in_ready", 32'(in_ready), 32'd1 << (i % 4));
            push(SELW'(i % 4));
            tick();
        end
        in_valid = '0;
        tick();
        for (int c = 0; c < NCH; c++) chk("rr_fair", 32'(gcount[c]), 32'd2);

        // Round-robin skip and wrap: ptr is 0 here.
        in_valid = 4'b0100;
        #1;
        chk("skip_ch2", 32'(in_ready), 32'b0100);
        push(2'd2);
        tick();
        in_valid = 4'b0010;
        #1;
        chk("skip_ch1", 32'(in_ready), 32'b0010);
        push(2'd1);
        tick();
        in_valid = 4'b1001;
        #1;
        chk("skip_ch3", 32'(in_ready), 32'b1000);
        push(2'd3);
        tick();
        chk("wrap_ch0", 32'(in_ready), 32'b0001);
        push(2'd0);
        tick();
        in_valid = '0;
        tick();

        // Reset while an entry is held; ptr would otherwise be 3.
        in_valid = 4'b0100;
        #1;
        tick();
        out_ready = 1'b0;
        in_valid  = '0;
        #1;
        chk("rst_mid_pre_valid", 32'(out_valid), 32'd1);
        rst     = 1'b1;
        exp_cnt = '0;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_out_ch", 32'(out_ch), 32'd0);
        chk("rst_mid_out_data", 32'(out_data), 32'd0);
        tick();
        rst       = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("rst_mid_ptr", 32'(in_ready), 32'b0001);
        push(2'd0);
        tick();

        // Backpressure: held entry is ch0 with data 3; inputs keep changing.
        out_ready = 1'b0;
        in_data   = 8'b01_10_11_00;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_ch", 32'(out_ch), 32'd0);
            chk("bp_out_data", 32'(out_data), 32'd3);
            chk("bp_xfer_cnt", 32'(xfer_cnt), 32'(cnt_exp()));
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ch1", 32'(in_ready), 32'b0010);
        push(2'd1);
        tick();
        in_valid = '0;
        tick();
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_xfer_cnt_end", 32'(xfer_cnt), 32'(cnt_exp()));

`ifdef MUX_ARB_CNT_EN
        // Drive the counter up to 0xFFFF, then one more transfer to wrap.
        mode     = 1'b0;
        sel      = 2'd0;
        in_valid = 4'b0001;
        n        = 32'hFFFF - int'(exp_cnt);
        #1;
        for (int i = 0; i < n; i++) begin
            push(2'd0);
            tick();
        end
        in_valid = '0;
        tick();
        chk("cnt_preload", 32'(xfer_cnt), 32'hFFFF);
        in_valid = 4'b0001;
        #1;
        push(2'd0);
        tick();
        in_valid = '0;
        tick();
        chk("cnt_wrap", 32'(xfer_cnt), 32'h0);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
